// File: rtl/vdp_slot_io_responder_if.sv
// Internal VDP bus between the slot responder (master) and the VDP core (slave).
// A request is held on bus_valid until bus_ready; read data returns on a bus_rdata_en pulse.
interface vdp_slot_io_responder_if;
  logic       bus_valid;
  logic       bus_ready;
  logic       bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport master (
    output bus_valid,
    output bus_write,
    output bus_address,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata,
    input  bus_rdata_en
  );

  modport slave (
    input  bus_valid,
    input  bus_write,
    input  bus_address,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata,
    output bus_rdata_en
  );
endinterface

// File: rtl/vdp_slot_io_responder.sv
// MSX slot I/O responder: turns each Z80 IN/OUT on the IO_BASE..IO_BASE+3 window into one VDP bus request.
// Define VDP_SLOT_WAIT_EN to build the /WAIT stretching logic; otherwise slot_wait is tied low.
module vdp_slot_io_responder #(
  parameter logic [7:0] IO_BASE     = 8'h88,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  vdp_slot_io_responder_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] iorq_sync_q, rd_sync_q, wr_sync_q;
  logic iorq_s, rd_s, wr_s;
  logic wr_act, rd_act, hit;

  logic       armed_q, armed_d;
  logic       bus_valid_q, bus_valid_d;
  logic       bus_write_q, bus_write_d;
  logic [1:0] bus_address_q, bus_address_d;
  logic [7:0] bus_wdata_q, bus_wdata_d;
  logic [7:0] slot_d_out_q, slot_d_out_d;
  logic       slot_data_dir_q, slot_data_dir_d;

  // Synchronizers reset to "strobe asserted": a cycle already in progress when reset
  // lifts must not look like /IORQ was high, otherwise armed_q would re-arm mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iorq_sync_q <= '0;
      rd_sync_q   <= '0;
      wr_sync_q   <= '0;
    end else begin
      iorq_sync_q <= {iorq_sync_q[SYNC_STAGES-2:0], slot_iorq_n};
      rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], slot_rd_n};
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], slot_wr_n};
    end
  end

  assign iorq_s = iorq_sync_q[SYNC_STAGES-1];
  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];

  // /RD and /WR both low is not a legal Z80 cycle, so each action demands the other strobe high.
  assign wr_act = ~iorq_s & ~wr_s &  rd_s;
  assign rd_act = ~iorq_s & ~rd_s &  wr_s;
  assign hit    = (slot_a[7:2] == IO_BASE[7:2]);

  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q | iorq_s;
    bus_valid_d   = bus_valid_q;
    bus_write_d   = bus_write_q;
    bus_address_d = bus_address_q;
    bus_wdata_d   = bus_wdata_q;
    slot_d_out_d  = slot_d_out_q;

    case (state_q)
      IDLE: begin
        // armed_q guarantees one transaction per /IORQ low period.
        if (armed_q && hit && wr_act) begin
          armed_d       = 1'b0;
          bus_valid_d   = 1'b1;
          bus_write_d   = 1'b1;
          bus_address_d = slot_a[1:0];
          bus_wdata_d   = slot_d_in;
          state_d       = WR_REQ;
        end else if (armed_q && hit && rd_act) begin
          armed_d       = 1'b0;
          bus_valid_d   = 1'b1;
          bus_write_d   = 1'b0;
          bus_address_d = slot_a[1:0];
          state_d       = RD_REQ;
        end
      end
      WR_REQ: begin
        if (bus.bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RD_REQ: begin
        if (bus.bus_ready) begin
          bus_valid_d = 1'b0;
          if (!bus.bus_rdata_en) begin
            state_d = RD_WAIT;
          end else if (!rd_s) begin
            slot_d_out_d = bus.bus_rdata;
            state_d      = RD_HOLD;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RD_WAIT: begin
        // Data arriving after the Z80 already let go of /RD is dropped.
        if (bus.bus_rdata_en) begin
          if (!rd_s) begin
            slot_d_out_d = bus.bus_rdata;
            state_d      = RD_HOLD;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RD_HOLD: begin
        if (rd_s || iorq_s) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (iorq_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    slot_data_dir_d = (state_d inside {RD_REQ, RD_WAIT, RD_HOLD}) && !rd_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      armed_q         <= 1'b0;
      bus_valid_q     <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_address_q   <= 2'd0;
      bus_wdata_q     <= 8'h00;
      slot_d_out_q    <= 8'h00;
      slot_data_dir_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      armed_q         <= armed_d;
      bus_valid_q     <= bus_valid_d;
      bus_write_q     <= bus_write_d;
      bus_address_q   <= bus_address_d;
      bus_wdata_q     <= bus_wdata_d;
      slot_d_out_q    <= slot_d_out_d;
      slot_data_dir_q <= slot_data_dir_d;
    end
  end

`ifdef VDP_SLOT_WAIT_EN
  logic slot_wait_q, slot_wait_d;

  // Stretch the Z80 cycle until read data is on the pins or the write has been taken.
  assign slot_wait_d = (state_d inside {WR_REQ, RD_REQ, RD_WAIT});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_wait_q <= 1'b0;
    end else begin
      slot_wait_q <= slot_wait_d;
    end
  end

  assign slot_wait = slot_wait_q;
`else
  assign slot_wait = 1'b0;
`endif

  assign bus.bus_valid   = bus_valid_q;
  assign bus.bus_write   = bus_write_q;
  assign bus.bus_address = bus_address_q;
  assign bus.bus_wdata   = bus_wdata_q;
  assign slot_d_out      = slot_d_out_q;
  assign slot_data_dir   = slot_data_dir_q;

endmodule

// File: tb/tb_vdp_slot_io_responder.sv
// Scoreboard bench for vdp_slot_io_responder: expected bus transactions are queued as slot
// cycles are driven and matched against transactions captured on the internal bus.
module tb_vdp_slot_io_responder;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slot_iorq_n = 1'b1;
  logic       slot_rd_n = 1'b1;
  logic       slot_wr_n = 1'b1;
  logic [7:0] slot_a = 8'h00;
  logic [7:0] slot_d_in = 8'h00;
  logic [7:0] slot_d_out;
  logic       slot_data_dir;
  logic       slot_wait;

  always #5 clk = ~clk;

  vdp_slot_io_responder_if bus_if();

  vdp_slot_io_responder #(
    .IO_BASE    (8'h88),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .slot_iorq_n  (slot_iorq_n),
    .slot_rd_n    (slot_rd_n),
    .slot_wr_n    (slot_wr_n),
    .slot_a       (slot_a),
    .slot_d_in    (slot_d_in),
    .slot_d_out   (slot_d_out),
    .slot_data_dir(slot_data_dir),
    .slot_wait    (slot_wait),
    .bus          (bus_if.master)
  );

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       seen_q[$];
  logic [7:0] rd_exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  // Capture every accepted request; read requests carry no write data.
  always @(negedge clk) begin
    if (!reset && bus_if.bus_valid === 1'b1 && bus_if.bus_ready === 1'b1) begin
      seen_q.push_back({bus_if.bus_write, bus_if.bus_address,
                        (bus_if.bus_write ? bus_if.bus_wdata : 8'h00)});
    end
  end

  task automatic strobe_low(input logic [7:0] a, input logic [7:0] d, input logic is_wr);
    @(posedge clk); #1;
    slot_a      = a;
    slot_d_in   = d;
    slot_iorq_n = 1'b0;
    if (is_wr) slot_wr_n = 1'b0;
    else       slot_rd_n = 1'b0;
  endtask

  task automatic strobe_high();
    @(posedge clk); #1;
    slot_iorq_n = 1'b1;
    slot_rd_n   = 1'b1;
    slot_wr_n   = 1'b1;
  endtask

  // Number of clock edges until bus_valid is seen, or -1 if the bound expires.
  task automatic wait_valid(input int limit, output int edges);
    edges = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus_if.bus_valid === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic wait_dir_low(input int limit, output int edges);
    edges = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (slot_data_dir === 1'b0) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.bus_ready    = 1'b0;
    bus_if.bus_rdata    = 8'h00;
    bus_if.bus_rdata_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({slot_d_out, slot_data_dir, slot_wait, bus_if.bus_valid, bus_if.bus_write,
         bus_if.bus_address, bus_if.bus_wdata} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got d_out=%h dir=%b wait=%b valid=%b write=%b addr=%h wdata=%h required all 0",
               slot_d_out, slot_data_dir, slot_wait, bus_if.bus_valid, bus_if.bus_write,
               bus_if.bus_address, bus_if.bus_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus_if.bus_valid !== 1'b0 || slot_data_dir !== 1'b0 || slot_wait !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got valid=%b dir=%b wait=%b required 0 0 0",
               bus_if.bus_valid, slot_data_dir, slot_wait);
    end
    $display("reset: done");
  endtask

  task automatic test_write();
    int   edges;
    int   pulse;
    bit   dir_seen;
    txn_t s, e;
    bus_if.bus_ready = 1'b1;
    exp_q.push_back({1'b1, 2'd1, 8'h80});
    strobe_low(8'h89, 8'h80, 1'b1);
    edges = -1; pulse = 0; dir_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (slot_data_dir !== 1'b0) dir_seen = 1'b1;
      if (bus_if.bus_valid === 1'b1) begin
        if (edges < 0) edges = i;
        pulse++;
      end
    end
    strobe_high();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (slot_data_dir !== 1'b0) dir_seen = 1'b1;
    end
    vectors++;
    if (edges !== SYNC + 1) begin
      miscompares++;
      $display("FAIL write_latency: got %0d clk required %0d", edges, SYNC + 1);
    end
    vectors++;
    if (pulse !== 1) begin
      miscompares++;
      $display("FAIL write_valid_pulse: got %0d clk high required 1", pulse);
    end
    vectors++;
    if (dir_seen) begin
      miscompares++;
      $display("FAIL write_data_dir: got dir=1 during write required 0");
    end
    vectors++;
    if (seen_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL write_txn_count: got %0d required %0d", seen_q.size(), exp_q.size());
    end
    while (seen_q.size() > 0 && exp_q.size() > 0) begin
      s = seen_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (s !== e) begin
        miscompares++;
        $display("FAIL write_txn: got %h required %h", s, e);
      end else $display("write: txn wr=%b addr=%0d data=%h", s.wr, s.addr, s.data);
    end
    exp_q.delete(); seen_q.delete();
  endtask

  task automatic test_read();
    int         edges;
    txn_t       s, e;
    logic [7:0] rexp;
    bus_if.bus_ready = 1'b1;
    exp_q.push_back({1'b0, 2'd3, 8'h00});
    rd_exp_q.push_back(8'h5A);
    strobe_low(8'h8B, 8'h00, 1'b0);
    wait_valid(20, edges);
    vectors++;
    if (edges !== SYNC + 1) begin
      miscompares++;
      $display("FAIL read_latency: got %0d clk required %0d", edges, SYNC + 1);
    end
    vectors++;
    if (slot_data_dir !== 1'b1) begin
      miscompares++;
      $display("FAIL read_dir_req: got %b required 1", slot_data_dir);
    end
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    bus_if.bus_rdata    = 8'h5A;
    bus_if.bus_rdata_en = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_rdata_en = 1'b0;
    bus_if.bus_rdata    = 8'h00;
    repeat (3) @(negedge clk);
    rexp = rd_exp_q.pop_front();
    vectors++;
    if (slot_data_dir !== 1'b1 || slot_d_out !== rexp) begin
      miscompares++;
      $display("FAIL read_data: got dir=%b d_out=%h required dir=1 d_out=%h", slot_data_dir, slot_d_out, rexp);
    end else $display("read: slot data %h", slot_d_out);
    strobe_high();
    wait_dir_low(20, edges);
    vectors++;
    if (edges !== SYNC + 1) begin
      miscompares++;
      $display("FAIL read_dir_release: got %0d clk required %0d", edges, SYNC + 1);
    end
    repeat (4) @(posedge clk);
    vectors++;
    if (seen_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL read_txn_count: got %0d required %0d", seen_q.size(), exp_q.size());
    end
    while (seen_q.size() > 0 && exp_q.size() > 0) begin
      s = seen_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (s !== e) begin
        miscompares++;
        $display("FAIL read_txn: got %h required %h", s, e);
      end else $display("read: txn wr=%b addr=%0d", s.wr, s.addr);
    end
    exp_q.delete(); seen_q.delete();
  endtask

  task automatic test_miss();
    logic [7:0] addrs [2];
    logic       wrs   [2];
    bit         bad;
    addrs[0] = 8'h98; wrs[0] = 1'b1;
    addrs[1] = 8'h8C; wrs[1] = 1'b0;
    bus_if.bus_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bad = 1'b0;
      strobe_low(addrs[k], 8'hA5, wrs[k]);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (bus_if.bus_valid !== 1'b0 || slot_data_dir !== 1'b0 || slot_wait !== 1'b0) bad = 1'b1;
      end
      strobe_high();
      repeat (4) @(posedge clk);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL miss_quiet: port %h produced valid/dir/wait activity required none", addrs[k]);
      end else $display("miss: port %h ignored", addrs[k]);
    end
    vectors++;
    if (seen_q.size() !== 0) begin
      miscompares++;
      $display("FAIL miss_txn_count: got %0d required 0", seen_q.size());
    end
    seen_q.delete();
  endtask

  task automatic test_stall();
    int   edges;
    int   unstable;
    bit   retrig;
    logic exp_wait;
    txn_t s, e;
`ifdef VDP_SLOT_WAIT_EN
    exp_wait = 1'b1;
`else
    exp_wait = 1'b0;
`endif
    bus_if.bus_ready = 1'b0;
    exp_q.push_back({1'b1, 2'd0, 8'h33});
    strobe_low(8'h88, 8'h33, 1'b1);
    wait_valid(20, edges);
    vectors++;
    if (edges !== SYNC + 1) begin
      miscompares++;
      $display("FAIL stall_latency: got %0d clk required %0d", edges, SYNC + 1);
    end
    unstable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.bus_valid !== 1'b1 || bus_if.bus_write !== 1'b1 || bus_if.bus_address !== 2'd0 ||
          bus_if.bus_wdata !== 8'h33 || slot_wait !== exp_wait) unstable++;
    end
    vectors++;
    if (unstable !== 0) begin
      miscompares++;
      $display("FAIL stall_hold: got %0d unstable clk required 0 (last valid=%b write=%b addr=%0d wdata=%h wait=%b want wait=%b)",
               unstable, bus_if.bus_valid, bus_if.bus_write, bus_if.bus_address, bus_if.bus_wdata, slot_wait, exp_wait);
    end
    @(posedge clk); #1;
    bus_if.bus_ready = 1'b1;
    @(posedge clk);
    retrig = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.bus_valid !== 1'b0 || slot_wait !== 1'b0) retrig = 1'b1;
    end
    vectors++;
    if (retrig) begin
      miscompares++;
      $display("FAIL stall_no_retrigger: valid or wait active with strobe still held, required 0");
    end
    strobe_high();
    repeat (4) @(posedge clk);
    vectors++;
    if (seen_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL stall_txn_count: got %0d required %0d", seen_q.size(), exp_q.size());
    end
    while (seen_q.size() > 0 && exp_q.size() > 0) begin
      s = seen_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (s !== e) begin
        miscompares++;
        $display("FAIL stall_txn: got %h required %h", s, e);
      end else $display("stall: txn wr=%b addr=%0d data=%h", s.wr, s.addr, s.data);
    end
    exp_q.delete(); seen_q.delete();
  endtask

  task automatic test_early_release();
    int   edges;
    txn_t s, e;
    bus_if.bus_ready    = 1'b0;
    bus_if.bus_rdata_en = 1'b0;
    exp_q.push_back({1'b0, 2'd2, 8'h00});
    strobe_low(8'h8A, 8'h00, 1'b0);
    wait_valid(20, edges);
    vectors++;
    if (edges !== SYNC + 1 || slot_data_dir !== 1'b1) begin
      miscompares++;
      $display("FAIL early_req: got latency=%0d dir=%b required %0d 1", edges, slot_data_dir, SYNC + 1);
    end
    @(posedge clk); #1;
    slot_rd_n = 1'b1;
    wait_dir_low(20, edges);
    vectors++;
    if (edges !== SYNC + 1) begin
      miscompares++;
      $display("FAIL early_dir_drop: got %0d clk required %0d", edges, SYNC + 1);
    end
    vectors++;
    if (bus_if.bus_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL early_req_kept: got valid=%b required 1", bus_if.bus_valid);
    end
    @(posedge clk); #1;
    bus_if.bus_ready    = 1'b1;
    bus_if.bus_rdata    = 8'hEE;
    bus_if.bus_rdata_en = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_rdata_en = 1'b0;
    bus_if.bus_rdata    = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus_if.bus_valid !== 1'b0 || slot_data_dir !== 1'b0 || slot_d_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL early_discard: got valid=%b dir=%b d_out=%h required 0 0 5a",
               bus_if.bus_valid, slot_data_dir, slot_d_out);
    end
    strobe_high();
    repeat (4) @(posedge clk);
    vectors++;
    if (seen_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL early_txn_count: got %0d required %0d", seen_q.size(), exp_q.size());
    end
    while (seen_q.size() > 0 && exp_q.size() > 0) begin
      s = seen_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (s !== e) begin
        miscompares++;
        $display("FAIL early_txn: got %h required %h", s, e);
      end else $display("early_release: txn wr=%b addr=%0d", s.wr, s.addr);
    end
    exp_q.delete(); seen_q.delete();
  endtask

  task automatic test_reset_mid();
    int   edges;
    bit   resumed;
    txn_t s, e;
    bus_if.bus_ready    = 1'b1;
    bus_if.bus_rdata_en = 1'b0;
    exp_q.push_back({1'b0, 2'd1, 8'h00});
    strobe_low(8'h89, 8'h00, 1'b0);
    wait_valid(20, edges);
    @(posedge clk); #1;
    vectors++;
    if (slot_data_dir !== 1'b1 || bus_if.bus_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_in_rd_wait: got dir=%b valid=%b required 1 0", slot_data_dir, bus_if.bus_valid);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (slot_data_dir !== 1'b0 || bus_if.bus_valid !== 1'b0 || slot_d_out !== 8'h00 || slot_wait !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: got dir=%b valid=%b d_out=%h wait=%b required 0 0 00 0",
               slot_data_dir, bus_if.bus_valid, slot_d_out, slot_wait);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    resumed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.bus_valid !== 1'b0 || slot_data_dir !== 1'b0) resumed = 1'b1;
    end
    vectors++;
    if (resumed) begin
      miscompares++;
      $display("FAIL rstmid_no_resume: activity after reset with strobe held, required none");
    end
    strobe_high();
    repeat (4) @(posedge clk);
    #1;
    bus_if.bus_rdata    = 8'hC3;
    bus_if.bus_rdata_en = 1'b1;
    exp_q.push_back({1'b0, 2'd1, 8'h00});
    rd_exp_q.push_back(8'hC3);
    strobe_low(8'h89, 8'h00, 1'b0);
    wait_valid(20, edges);
    vectors++;
    if (edges !== SYNC + 1) begin
      miscompares++;
      $display("FAIL rstmid_next_latency: got %0d clk required %0d", edges, SYNC + 1);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (slot_data_dir !== 1'b1 || slot_d_out !== rd_exp_q[0]) begin
      miscompares++;
      $display("FAIL rstmid_next_read: got dir=%b d_out=%h required 1 %h", slot_data_dir, slot_d_out, rd_exp_q[0]);
    end else $display("reset_mid: next read data %h", slot_d_out);
    void'(rd_exp_q.pop_front());
    bus_if.bus_rdata_en = 1'b0;
    strobe_high();
    repeat (5) @(posedge clk);
    vectors++;
    if (seen_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL rstmid_txn_count: got %0d required %0d", seen_q.size(), exp_q.size());
    end
    while (seen_q.size() > 0 && exp_q.size() > 0) begin
      s = seen_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (s !== e) begin
        miscompares++;
        $display("FAIL rstmid_txn: got %h required %h", s, e);
      end else $display("reset_mid: txn wr=%b addr=%0d", s.wr, s.addr);
    end
    exp_q.delete(); seen_q.delete();
  endtask

  task automatic test_back_to_back();
    txn_t s, e;
    bus_if.bus_ready = 1'b1;
    for (int i = 0; i < 960; i++) begin
      exp_q.push_back({1'b1, 2'd0, 8'(i)});
      strobe_low(8'h88, 8'(i), 1'b1);
      repeat (6) @(posedge clk);
      strobe_high();
      repeat (2) @(posedge clk);
    end
    repeat (6) @(posedge clk);
    vectors++;
    if (seen_q.size() !== 960) begin
      miscompares++;
      $display("FAIL b2b_txn_count: got %0d required 960", seen_q.size());
    end
    for (int i = 0; seen_q.size() > 0 && exp_q.size() > 0; i++) begin
      s = seen_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (s !== e) begin
        miscompares++;
        $display("FAIL b2b_txn[%0d]: got %h required %h", i, s, e);
      end else $display("b2b: txn %0d data=%h", i, s.data);
    end
    exp_q.delete(); seen_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_miss();
    test_stall();
    test_early_release();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
